// File: rtl/datapath_pkg.sv
// Shared types and helpers for the parametrised LC-3-style datapath.
package datapath_pkg;

  localparam int unsigned XW = 64;

  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} alu_op_e;
  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDER, PC_HOLD} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
  typedef enum logic [1:0] {MEM_IDLE, MEM_READ, MEM_WRITE} mem_state_e;

  // Sign-extends the low 'bits' bits of v; callers cast the result down to their width.
  function automatic logic [XW-1:0] sext(input logic [XW-1:0] v, input int unsigned bits);
    logic [XW-1:0] r;
    logic          s;
    s = v[bits[5:0] - 6'd1];
    r = v;
    for (int unsigned i = 0; i < XW; i++)
      if (i >= bits) r[i] = s;
    return r;
  endfunction

endpackage

// File: rtl/datapath_mem_fsm.sv
// Memory interface FSM: req/ack handshake with latched address/data and a timeout.
module datapath_mem_fsm
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mar,
  input  logic [WIDTH-1:0] mdr,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_busy,
  output logic             rd_active,
  output logic             rd_done,
  output logic             mem_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  mem_state_e    state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: begin
        if (mem_rd)      state_nxt = MEM_READ;
        else if (mem_wr) state_nxt = MEM_WRITE;
      end
      MEM_READ, MEM_WRITE: begin
        if (mem_ack || timed_out) state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state != MEM_IDLE);
    mem_we    = (state == MEM_WRITE);
    mem_busy  = (state != MEM_IDLE);
    rd_active = (state == MEM_READ);
    rd_done   = (state == MEM_READ) && mem_ack;
  end

  // A simultaneous rd+wr is a read, so the write data latch is left alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
    end else if (state == MEM_IDLE) begin
      wait_cnt <= '0;
      if (mem_rd || mem_wr) mem_addr <= mar;
      if (!mem_rd && mem_wr) mem_wdata <= mdr;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
      if (!mem_ack && timed_out) mem_err <= 1'b1;
    end
  end

endmodule

// File: rtl/datapath_gen.sv
// Parametrised LC-3-style datapath with NZP/BEN logic, bus-contention flag and memory FSM.
module datapath_gen
  import datapath_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter int unsigned     NREG     = 8,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter int unsigned     TIMEOUT  = 15
) (
  input  logic             Clk,
  input  logic             Reset_al,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic             Mem_rd,
  input  logic             Mem_wr,
  input  logic [WIDTH-1:0] Mem_rdata,
  input  logic             Mem_ack,
  output logic             Mem_req,
  output logic             Mem_we,
  output logic [WIDTH-1:0] Mem_addr,
  output logic [WIDTH-1:0] Mem_wdata,
  output logic             Mem_busy,
  output logic             Mem_err,
  output logic             Bus_err,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [2:0]       NZP,
  output logic             BEN
);

  localparam int unsigned RAW = $clog2(NREG);

  logic [WIDTH-1:0] regs [NREG];
  logic [RAW-1:0]   dr_f, sr1_f, sr2_f, sr1_addr, dr_addr;
  logic [WIDTH-1:0] imm5, off6, off9, off11;
  logic [WIDTH-1:0] sr1_val, sr2_val, alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder, bus, pc_next;
  logic             bus_multi, rd_active, rd_done;

  assign dr_f  = IR[WIDTH-5 -: RAW];
  assign sr1_f = IR[WIDTH-5-RAW -: RAW];
  assign sr2_f = IR[RAW-1:0];

  assign imm5  = WIDTH'(sext(XW'(IR[4:0]), 5));
  assign off6  = WIDTH'(sext(XW'(IR[5:0]), 6));
  assign off9  = WIDTH'(sext(XW'(IR[8:0]), 9));
  assign off11 = WIDTH'(sext(XW'(IR[10:0]), 11));

  assign sr1_addr = SR1MUX ? sr1_f : dr_f;
  assign dr_addr  = DRMUX ? RAW'(NREG - 1) : dr_f;
  assign sr1_val  = regs[sr1_addr];
  assign sr2_val  = regs[sr2_f];
  assign alu_b    = SR2MUX ? imm5 : sr2_val;
  assign addr1    = ADDR1MUX ? sr1_val : PC;
  assign adder    = addr1 + addr2;

  always_comb begin
    alu_out = '0;
    case (alu_op_e'(ALUK))
      ALU_ADD:  alu_out = sr1_val + alu_b;
      ALU_AND:  alu_out = sr1_val & alu_b;
      ALU_NOT:  alu_out = ~sr1_val;
      ALU_PASS: alu_out = sr1_val;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    addr2 = '0;
    case (addr2mux_e'(ADDR2MUX))
      A2_ZERO:  addr2 = '0;
      A2_OFF6:  addr2 = off6;
      A2_OFF9:  addr2 = off9;
      A2_OFF11: addr2 = off11;
      default:  addr2 = '0;
    endcase
  end

  always_comb begin
    bus = '0;
    if (GatePC)          bus = PC;
    else if (GateMDR)    bus = MDR;
    else if (GateALU)    bus = alu_out;
    else if (GateMARMUX) bus = adder;
  end

  assign bus_multi = $countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1;

  always_comb begin
    pc_next = PC;
    case (pcmux_e'(PCMUX))
      PC_INC:   pc_next = PC + 1'b1;
      PC_BUS:   pc_next = bus;
      PC_ADDER: pc_next = adder;
      PC_HOLD:  pc_next = PC;
      default:  pc_next = PC;
    endcase
  end

  // A read completion owns MDR that cycle; LD_MDR is locked out for the whole read.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      PC      <= PC_RESET;
      MAR     <= '0;
      MDR     <= '0;
      IR      <= '0;
      NZP     <= 3'b010;
      BEN     <= 1'b0;
      Bus_err <= 1'b0;
    end else begin
      if (LD_PC)  PC  <= pc_next;
      if (LD_MAR) MAR <= bus;
      if (LD_IR)  IR  <= bus;
      if (rd_done)                   MDR <= Mem_rdata;
      else if (LD_MDR && !rd_active) MDR <= bus;
      if (LD_CC)  NZP <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
      if (LD_BEN) BEN <= |(IR[WIDTH-5 -: 3] & NZP);
      if (bus_multi) Bus_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (LD_REG) begin
      regs[dr_addr] <= bus;
    end
  end

  datapath_mem_fsm #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) u_mem_fsm (
    .clk      (Clk),
    .rst_n    (Reset_al),
    .mem_rd   (Mem_rd),
    .mem_wr   (Mem_wr),
    .mem_ack  (Mem_ack),
    .mar      (MAR),
    .mdr      (MDR),
    .mem_req  (Mem_req),
    .mem_we   (Mem_we),
    .mem_busy (Mem_busy),
    .rd_active(rd_active),
    .rd_done  (rd_done),
    .mem_err  (Mem_err),
    .mem_addr (Mem_addr),
    .mem_wdata(Mem_wdata)
  );

endmodule

// File: tb/tb_datapath_gen.sv
// Self-checking bench: a 16-bit/8-reg instance and a 32-bit/16-reg instance on shared controls.
module tb_datapath_gen;

  logic Clk = 1'b0;
  logic Reset_al = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic Mem_rd, Mem_wr, Mem_ack;
  logic [15:0] rdata_a;
  logic [31:0] rdata_b;

  logic        req_a, we_a, busy_a, merr_a, berr_a, ben_a;
  logic [15:0] addr_a, wdata_a, MAR_a, MDR_a, IR_a, PC_a;
  logic [2:0]  nzp_a;
  logic        req_b, we_b, busy_b, merr_b, berr_b, ben_b;
  logic [31:0] addr_b, wdata_b, MAR_b, MDR_b, IR_b, PC_b;
  logic [2:0]  nzp_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_reg [8];
  logic [15:0] m_pc;

  always #5 Clk = ~Clk;

  datapath_gen #(.WIDTH(16), .NREG(8), .PC_RESET(16'h0000), .TIMEOUT(15)) u_a (
    .Clk(Clk), .Reset_al(Reset_al),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Mem_rdata(rdata_a), .Mem_ack(Mem_ack),
    .Mem_req(req_a), .Mem_we(we_a), .Mem_addr(addr_a), .Mem_wdata(wdata_a),
    .Mem_busy(busy_a), .Mem_err(merr_a), .Bus_err(berr_a),
    .MAR(MAR_a), .MDR(MDR_a), .IR(IR_a), .PC(PC_a), .NZP(nzp_a), .BEN(ben_a)
  );

  datapath_gen #(.WIDTH(32), .NREG(16), .PC_RESET(32'h0000_0100), .TIMEOUT(4)) u_b (
    .Clk(Clk), .Reset_al(Reset_al),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Mem_rdata(rdata_b), .Mem_ack(Mem_ack),
    .Mem_req(req_b), .Mem_we(we_b), .Mem_addr(addr_b), .Mem_wdata(wdata_b),
    .Mem_busy(busy_b), .Mem_err(merr_b), .Bus_err(berr_b),
    .MAR(MAR_b), .MDR(MDR_b), .IR(IR_b), .PC(PC_b), .NZP(nzp_b), .BEN(ben_b)
  );

  function automatic logic [15:0] sx(input logic [15:0] v, input int n);
    logic [15:0] m, r;
    m = (16'h1 << n) - 16'h1;
    r = v & m;
    if (r[n-1]) r = r | ~m;
    return r;
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic clr();
    LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0; LD_PC = 0;
    GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
    PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
    DRMUX = 0; SR1MUX = 0; SR2MUX = 0; ADDR1MUX = 0;
    Mem_rd = 0; Mem_wr = 0; Mem_ack = 0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    Reset_al = 0;
    cyc();
    cyc();
    Reset_al = 1;
    cyc();
    m_pc = 16'h0000;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
  endtask

  task automatic set_mdr(input logic [31:0] v);
    clr();
    Mem_rd = 1;
    cyc();
    Mem_rd = 0; Mem_ack = 1; rdata_a = v[15:0]; rdata_b = v;
    cyc();
    clr();
  endtask

  task automatic set_ir(input logic [31:0] v);
    set_mdr(v);
    GateMDR = 1; LD_IR = 1;
    cyc();
    clr();
  endtask

  task automatic write_reg(input int r, input logic [15:0] v);
    set_ir(32'(r) << 9);
    set_mdr({16'h0, v});
    GateMDR = 1; LD_REG = 1;
    cyc();
    clr();
    m_reg[r] = v;
  endtask

  // Drives reg[SR1 field of irv] onto the bus through ALU pass-through into MAR.
  task automatic read_ir(input logic [31:0] irv);
    set_ir(irv);
    SR1MUX = 1; ALUK = 2'b11; GateALU = 1; LD_MAR = 1;
    cyc();
    clr();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (PC_a !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", PC_a, 16'h0000); end
    checks++; if ({MAR_a, MDR_a, IR_a} !== 48'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {MAR_a, MDR_a, IR_a}); end
    checks++; if (nzp_a !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b expected 010", nzp_a); end
    checks++; if ({ben_a, merr_a, berr_a, req_a, we_a, busy_a} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {ben_a, merr_a, berr_a, req_a, we_a, busy_a}); end
    checks++; if (PC_b !== 32'h0000_0100) begin errors++; $display("FAIL reset_pc_b: got %h expected %h", PC_b, 32'h100); end
  endtask

  task automatic test_pc();
    GatePC = 1; LD_MAR = 1; cyc(); clr();
    checks++; if (MAR_a !== 16'h0000) begin errors++; $display("FAIL mar_from_pc: got %h expected 0000", MAR_a); end
    PCMUX = 2'b00; LD_PC = 1; cyc(); clr();
    checks++; if (PC_a !== 16'h0001) begin errors++; $display("FAIL pc_inc: got %h expected 0001", PC_a); end
    PCMUX = 2'b11; LD_PC = 1; cyc(); clr();
    checks++; if (PC_a !== 16'h0001) begin errors++; $display("FAIL pc_hold: got %h expected 0001", PC_a); end
    set_mdr(32'hFFFF);
    GateMDR = 1; PCMUX = 2'b01; LD_PC = 1; cyc(); clr();
    checks++; if (PC_a !== 16'hFFFF) begin errors++; $display("FAIL pc_bus: got %h expected FFFF", PC_a); end
    PCMUX = 2'b00; LD_PC = 1; cyc(); clr();
    checks++; if (PC_a !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h expected 0000", PC_a); end
    m_pc = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] irv;
      irv = 16'($urandom);
      set_ir({16'h0, irv});
      PCMUX = 2'b10; ADDR1MUX = 0; ADDR2MUX = 2'b10; LD_PC = 1; cyc(); clr();
      m_pc = m_pc + sx(irv, 9);
      checks++; if (PC_a !== m_pc) begin errors++; $display("FAIL pc_adder[%0d]: got %h expected %h", i, PC_a, m_pc); end
    end
  endtask

  task automatic test_alu();
    logic [15:0] a, b, bv, res, irv;
    logic [2:0]  nzp_exp, n;
    int dr, op, useimm, imm;
    write_reg(1, 16'h0005);
    write_reg(2, 16'hFFFA);
    set_ir(32'h1642);
    SR1MUX = 1; SR2MUX = 0; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1; cyc(); clr();
    m_reg[3] = 16'hFFFF;
    checks++; if (nzp_a !== 3'b100) begin errors++; $display("FAIL add_nzp: got %b expected 100", nzp_a); end
    read_ir(32'(3) << 6);
    checks++; if (MAR_a !== 16'hFFFF) begin errors++; $display("FAIL add_r3: got %h expected FFFF", MAR_a); end
    set_ir(32'h0800);
    LD_BEN = 1; cyc(); clr();
    checks++; if (ben_a !== 1'b1) begin errors++; $display("FAIL ben_set: got %b expected 1", ben_a); end
    set_ir(32'h0600);
    LD_BEN = 1; cyc(); clr();
    checks++; if (ben_a !== 1'b0) begin errors++; $display("FAIL ben_clear: got %b expected 0", ben_a); end

    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i == 0) b = -a;
      dr = $urandom_range(0, 7); op = $urandom_range(0, 3);
      useimm = $urandom_range(0, 1); imm = $urandom_range(0, 31);
      write_reg(1, a);
      write_reg(2, b);
      irv = {4'b0001, 3'(dr), 3'd1, 1'(useimm), useimm != 0 ? 5'(imm) : 5'd2};
      set_ir({16'h0, irv});
      SR1MUX = 1; SR2MUX = 1'(useimm); ALUK = 2'(op); GateALU = 1; LD_REG = 1; LD_CC = 1; cyc(); clr();
      bv = (useimm != 0) ? sx(16'(imm), 5) : b;
      case (op)
        0: res = a + bv;
        1: res = a & bv;
        2: res = ~a;
        default: res = a;
      endcase
      m_reg[dr] = res;
      nzp_exp = nzp_of(res);
      checks++; if (nzp_a !== nzp_exp) begin errors++; $display("FAIL alu_nzp[%0d]: got %b expected %b", i, nzp_a, nzp_exp); end
      read_ir(32'(dr) << 6);
      checks++; if (MAR_a !== res) begin errors++; $display("FAIL alu_res[%0d] op%0d: got %h expected %h", i, op, MAR_a, res); end
      n = 3'($urandom);
      set_ir(32'(n) << 9);
      LD_BEN = 1; cyc(); clr();
      checks++; if (ben_a !== |(n & nzp_exp)) begin errors++; $display("FAIL ben[%0d]: got %b expected %b", i, ben_a, |(n & nzp_exp)); end
    end
  endtask

  task automatic test_addr();
    logic [15:0] v, irv, off, exp;
    int r, sel;
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 7); v = 16'($urandom); sel = $urandom_range(0, 3);
      write_reg(r, v);
      irv = (16'($urandom) & 16'hFE3F) | 16'(r << 6);
      set_ir({16'h0, irv});
      ADDR1MUX = 1; SR1MUX = 1; ADDR2MUX = 2'(sel); GateMARMUX = 1; LD_MAR = 1; cyc(); clr();
      case (sel)
        0: off = 16'h0;
        1: off = sx(irv, 6);
        2: off = sx(irv, 9);
        default: off = sx(irv, 11);
      endcase
      exp = m_reg[r] + off;
      checks++; if (MAR_a !== exp) begin errors++; $display("FAIL marmux[%0d] sel%0d: got %h expected %h", i, sel, MAR_a, exp); end
    end
  endtask

  task automatic test_mem_read();
    int busy_cnt, bad;
    logic [15:0] d;
    set_mdr(32'h3000);
    GateMDR = 1; LD_MAR = 1; cyc(); clr();
    busy_cnt = 0;
    Mem_rd = 1; cyc(); clr();
    if (busy_a) busy_cnt++;
    checks++; if ({req_a, we_a, addr_a} !== {2'b10, 16'h3000}) begin errors++; $display("FAIL rd_start: got req%b we%b addr%h expected req1 we0 addr3000", req_a, we_a, addr_a); end
    GatePC = 1; LD_MAR = 1; LD_MDR = 1; cyc(); clr();
    if (busy_a) busy_cnt++;
    checks++; if ({MAR_a, addr_a, MDR_a} !== {m_pc, 16'h3000, 16'h3000}) begin errors++; $display("FAIL rd_hold: got mar%h addr%h mdr%h expected mar%h addr3000 mdr3000", MAR_a, addr_a, MDR_a, m_pc); end
    cyc();
    if (busy_a) busy_cnt++;
    Mem_ack = 1; rdata_a = 16'hBEEF; GatePC = 1; LD_MDR = 1; cyc(); clr();
    checks++; if ({MDR_a, busy_a} !== {16'hBEEF, 1'b0} || busy_cnt != 3) begin errors++; $display("FAIL rd_done: got mdr%h busy%b cnt%0d expected mdrBEEF busy0 cnt3", MDR_a, busy_a, busy_cnt); end

    for (int i = 0; i < 4; i++) begin
      int lat;
      lat = $urandom_range(1, 5); d = 16'($urandom); bad = 0;
      Mem_rd = 1; cyc(); clr();
      for (int k = 1; k < lat; k++) begin
        if (!busy_a) bad++;
        cyc();
      end
      if (!busy_a) bad++;
      Mem_ack = 1; rdata_a = d; cyc(); clr();
      checks++; if ({MDR_a, busy_a} !== {d, 1'b0} || bad != 0) begin errors++; $display("FAIL rd_rand[%0d] lat%0d: got mdr%h busy%b bad%0d expected mdr%h busy0 bad0", i, lat, MDR_a, busy_a, bad, d); end
    end

    Mem_rd = 1; Mem_wr = 1; cyc(); clr();
    checks++; if ({req_a, we_a} !== 2'b10) begin errors++; $display("FAIL rd_wins: got req%b we%b expected req1 we0", req_a, we_a); end
    Mem_ack = 1; rdata_a = 16'h5A5A; cyc(); clr();
    Mem_ack = 1; rdata_a = 16'h1234; cyc(); clr();
    checks++; if ({MDR_a, busy_a} !== {16'h5A5A, 1'b0}) begin errors++; $display("FAIL idle_ack: got mdr%h busy%b expected mdr5A5A busy0", MDR_a, busy_a); end
  endtask

  task automatic test_timeout();
    logic [15:0] addr, d;
    int req_cnt, early;
    addr = 16'($urandom); d = 16'($urandom);
    set_mdr({16'h0, addr});
    GateMDR = 1; LD_MAR = 1; cyc(); clr();
    set_mdr({16'h0, d});
    Mem_wr = 1; cyc(); clr();
    checks++; if ({we_a, addr_a, wdata_a} !== {1'b1, addr, d}) begin errors++; $display("FAIL wr_start: got we%b addr%h wdata%h expected we1 addr%h wdata%h", we_a, addr_a, wdata_a, addr, d); end
    req_cnt = 0; early = 0;
    for (int g = 0; g < 40 && req_a; g++) begin
      req_cnt++;
      if (merr_a) early++;
      cyc();
    end
    checks++; if (req_cnt != 15 || early != 0) begin errors++; $display("FAIL timeout_len: got %0d cycles (early err %0d) expected 15", req_cnt, early); end
    checks++; if ({merr_a, MDR_a} !== {1'b1, d}) begin errors++; $display("FAIL timeout_err: got err%b mdr%h expected err1 mdr%h", merr_a, MDR_a, d); end
    set_mdr(32'h0042);
    checks++; if ({merr_a, MDR_a} !== {1'b1, 16'h0042}) begin errors++; $display("FAIL err_sticky: got err%b mdr%h expected err1 mdr0042", merr_a, MDR_a); end
  endtask

  task automatic test_bus_err();
    do_reset();
    checks++; if ({berr_a, merr_a} !== 2'b00) begin errors++; $display("FAIL err_reset: got bus%b mem%b expected 00", berr_a, merr_a); end
    PCMUX = 2'b00; LD_PC = 1; cyc(); cyc(); clr();
    GatePC = 1; GateALU = 1; LD_MAR = 1; cyc(); clr();
    checks++; if ({MAR_a, berr_a} !== {16'h0002, 1'b1}) begin errors++; $display("FAIL bus_prio: got mar%h err%b expected mar0002 err1", MAR_a, berr_a); end
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (berr_a !== 1'b1) begin errors++; $display("FAIL bus_err_sticky: got %b expected 1", berr_a); end
    do_reset();
    checks++; if (berr_a !== 1'b0) begin errors++; $display("FAIL bus_err_clear: got %b expected 0", berr_a); end
  endtask

  task automatic test_wide();
    do_reset();
    set_ir(32'h0000_01FF);
    PCMUX = 2'b10; ADDR1MUX = 0; ADDR2MUX = 2'b10; LD_PC = 1; cyc(); clr();
    checks++; if (PC_b !== 32'h0000_00FF) begin errors++; $display("FAIL wide_sext: got %h expected 000000FF", PC_b); end
    set_ir(32'h0F00_0000);
    set_mdr(32'hCAFE_1234);
    GateMDR = 1; LD_REG = 1; cyc(); clr();
    read_ir(32'h00F0_0000);
    checks++; if (MAR_b !== 32'hCAFE_1234) begin errors++; $display("FAIL wide_r15: got %h expected CAFE1234", MAR_b); end
    set_ir(32'h0);
    set_mdr(32'h1357_9BDF);
    GateMDR = 1; LD_REG = 1; DRMUX = 1; cyc(); clr();
    read_ir(32'h00F0_0000);
    checks++; if (MAR_b !== 32'h1357_9BDF) begin errors++; $display("FAIL wide_link: got %h expected 13579BDF", MAR_b); end
    read_ir(32'h0);
    checks++; if (MAR_b !== 32'h0) begin errors++; $display("FAIL wide_r0: got %h expected 00000000", MAR_b); end
    Mem_rd = 1; cyc(); clr();
    checks++; if (req_b !== 1'b1) begin errors++; $display("FAIL wide_rd_req: got %b expected 1", req_b); end
    #2 Reset_al = 0;
    #1;
    checks++; if ({req_b, busy_b, req_a} !== 3'b000) begin errors++; $display("FAIL async_reset: got req_b%b busy_b%b req_a%b expected 000", req_b, busy_b, req_a); end
    cyc();
    Reset_al = 1;
    cyc();
    checks++; if ({busy_b, MDR_b, PC_b} !== {1'b0, 32'h0, 32'h100}) begin errors++; $display("FAIL post_reset: got busy%b mdr%h pc%h expected busy0 mdr0 pc100", busy_b, MDR_b, PC_b); end
  endtask

  initial begin
    clr();
    rdata_a = '0;
    rdata_b = '0;
    m_pc = '0;
    test_reset();
    test_pc();
    test_alu();
    test_addr();
    test_mem_read();
    test_timeout();
    test_bus_err();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_gen.md
# datapath_gen

Parametrised LC-3-style datapath: the next generation of the team's 16-bit datapath, generalised to WIDTH-bit data and NREG registers. It adds in-block NZP/BEN branch logic, a bus-contention error flag, and a memory-interface FSM (req/ack handshake with timeout) that replaces the direct MDR input path. It sits between the control-unit FSM and the memory/SRAM wrapper.

## Interface
- WIDTH, 16, data/address width; must be at least 16.
- NREG, 8, register count; must be 8 or 16. RAW = $clog2(NREG).
- PC_RESET, 0, PC value after reset.
- TIMEOUT, 15, maximum cycles to wait for Mem_ack; must be at least 1.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset_al  in  1  asynchronous, active-low reset.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drive enables.
- PCMUX, ADDR2MUX, ALUK  in  2 each  mux/ALU selects.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  in  1 each  mux selects.
- Mem_rd, Mem_wr  in  1 each  start a memory read or write.
- Mem_rdata  in  WIDTH  read data from memory.
- Mem_ack  in  1  memory completion.
- Mem_req  out  1  memory request.
- Mem_we  out  1  write qualifier, valid while Mem_req is high.
- Mem_addr, Mem_wdata  out  WIDTH  latched address and write data.
- Mem_busy  out  1  FSM is not in IDLE.
- Mem_err, Bus_err  out  1 each  sticky error flags.
- MAR, MDR, IR, PC  out  WIDTH  register contents.
- NZP  out  3  condition codes.
- BEN  out  1  branch enable.

## Operation
- Reset values: PC=PC_RESET; MAR, MDR, IR and all registers 0; NZP=3'b010; BEN=0; both error flags 0; FSM in IDLE; Mem_req=0, Mem_we=0.
- IR fields:
  - DR = IR[WIDTH-5 -: RAW]; SR1 = IR[WIDTH-5-RAW -: RAW]; SR2 = IR[RAW-1:0].
  - imm5 = IR[4:0]; off6 = IR[5:0]; off9 = IR[8:0]; off11 = IR[10:0]. All are sign-extended to WIDTH.
- Bus priority: PC > MDR > ALU > MARMUX. With no gate active, the bus is 0. Two or more gates active in any cycle sets Bus_err, which stays set until reset.
- SR1MUX: 0 selects DR, 1 selects SR1. DRMUX: 0 selects DR, 1 selects register NREG-1 (link register).
- SR2MUX: 0 selects reg[SR2], 1 selects imm5.
- ADDR1MUX: 0 selects PC, 1 selects reg[SR1 mux output].
- ADDR2MUX: 00 selects 0, 01 off6, 10 off9, 11 off11. Adder output = ADDR1 + ADDR2, modulo 2^WIDTH. It drives GateMARMUX.
- PCMUX: 00 selects PC+1 (wraps), 01 the bus, 10 the adder, 11 hold.
- ALUK: 00 ADD (wraps), 01 AND, 10 NOT A, 11 PASS A.
- Register file:
  - Reads are combinational; a write on LD_REG takes effect at the edge.
  - A read in the same cycle as a write to that register returns the old value.
- LD_CC: NZP <= {bus[WIDTH-1], bus==0, !bus[WIDTH-1] && bus!=0}, always one-hot.
- LD_BEN: BEN <= |(IR[WIDTH-5 -: 3] & NZP), using the current registered NZP.
- LD_MDR loads the bus into MDR. It is ignored while the FSM is in READ.
- Memory FSM states: IDLE, READ, WRITE.
  - IDLE: Mem_rd captures MAR into Mem_addr and goes to READ. Mem_wr captures MAR and MDR into Mem_addr/Mem_wdata and goes to WRITE. If both are asserted, the read wins and the write is dropped.
  - READ/WRITE: Mem_req=1; Mem_we=1 in WRITE only. The wait counter resets to 0 on entry.
  - On a sampled Mem_ack: return to IDLE. In READ, MDR <= Mem_rdata, taking priority over LD_MDR.
  - If TIMEOUT cycles pass with no ack: return to IDLE, set Mem_err (sticky), leave MDR unchanged.
  - Mem_rd/Mem_wr are ignored while busy. Mem_ack in IDLE is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, Mem_req drops asynchronously, and all reset values apply.

## Timing
- All loads take effect at the edge where their enable is sampled. NZP/BEN are visible the following cycle.
- Read latency: Mem_rd sampled at edge 0 → Mem_req high from edge 0. An ack sampled at edge k (k≥1) → MDR valid and Mem_busy low after edge k. Minimum is 1 cycle of Mem_req.
- Mem_addr and Mem_wdata are stable throughout the request; later MAR/MDR changes do not affect them.
- Timeout: Mem_req stays high for exactly TIMEOUT cycles, then drops together with Mem_err rising.

## Structure
- Package datapath_pkg:
  - Enums for alu_op_e, pcmux_e, addr2mux_e, mem_state_e.
  - Sign-extension function.
- One sub-module, datapath_mem_fsm, containing the state, wait counter, address/data latches and error flag. Everything else stays in datapath_gen.

## Test plan
- Reset, then GatePC+LD_MAR, then PCMUX=00+LD_PC → MAR=PC_RESET; PC=PC_RESET+1. With PC=16'hFFFF, PC wraps to 0.
- R1=5, R2=16'hFFFA (−6), IR=ADD R3,R1,R2; GateALU+LD_REG+LD_CC → R3=16'hFFFF, NZP=100. Then IR[11:9]=100 with LD_BEN → BEN=1.
- MAR=16'h3000, Mem_rd, ack on the 3rd Mem_req cycle with Mem_rdata=16'hBEEF → MDR=16'hBEEF; Mem_busy high for 3 cycles. Changing MAR during the wait does not change Mem_addr.
- Mem_wr with no ack and TIMEOUT=15 → Mem_req high for 15 cycles, Mem_we=1, then Mem_err=1 and MDR unchanged.
- GatePC and GateALU together for one cycle → bus=PC and Bus_err=1, still 1 after 10 idle cycles. Reset_al low clears it.
- NREG=16, WIDTH=32: IR with DR=4'hF, LD_REG → reg 15 written. DRMUX=1 also writes reg 15. Reset_al low mid-READ → Mem_req drops the same cycle.
